// File: rtl/riscv_instr_enc_if.sv
// Field-bundle input handshake and instruction-memory write bus for riscv_instr_enc.
// The encoder uses the slave modport; a producer/memory model uses master.
interface riscv_instr_enc_if #(
  parameter int ADDR_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic              funct7_5b;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [31:0]       imm;
  logic              imem_wr_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wr_data;
  logic              imem_ack;

  modport slave (
    input  in_valid, opcode, funct3, funct7_5b, rd, rs1, rs2, imm, imem_ack,
    output in_ready, imem_wr_en, imem_addr, imem_wr_data
  );

  modport master (
    output in_valid, opcode, funct3, funct7_5b, rd, rs1, rs2, imm, imem_ack,
    input  in_ready, imem_wr_en, imem_addr, imem_wr_data
  );
endinterface

// File: rtl/riscv_instr_enc.sv
// RV32I instruction encoder: packs decoded fields into words, buffers them and writes them
// to instruction memory at incrementing addresses. Optional macro: RISCV_ENC_ILLEGAL_CHK_EN.
module riscv_instr_enc #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic [ADDR_W-1:0] i_base_addr,
  riscv_instr_enc_if.slave  bus,
  output logic              o_busy,
  output logic              o_err_illegal,
  output logic [15:0]       o_count
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  function automatic logic known_op(input logic [6:0] op);
    logic ok;
    case (op)
      OP_R, OP_IMM, OP_LOAD, OP_JALR, OP_STORE,
      OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL: ok = 1'b1;
      default:                             ok = 1'b0;
    endcase
    return ok;
  endfunction

`ifdef RISCV_ENC_ILLEGAL_CHK_EN
  // Reject funct3/funct7 combinations that have no RV32I meaning.
  function automatic logic fields_ok(input logic [6:0] op, input logic [2:0] f3,
                                     input logic f7b);
    logic ok;
    ok = 1'b1;
    case (op)
      OP_BRANCH: if (f3 == 3'b010 || f3 == 3'b011) ok = 1'b0;
      OP_LOAD:   if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) ok = 1'b0;
      OP_STORE:  if (f3 >= 3'b011) ok = 1'b0;
      OP_JALR:   if (f3 != 3'b000) ok = 1'b0;
      OP_R:      if (f7b && f3 != 3'b000 && f3 != 3'b101) ok = 1'b0;
      default:   ok = 1'b1;
    endcase
    return ok;
  endfunction
`endif

  function automatic logic [31:0] enc_word(input logic [6:0] op, input logic [2:0] f3,
                                           input logic f7b, input logic [4:0] rd,
                                           input logic [4:0] rs1, input logic [4:0] rs2,
                                           input logic [31:0] imm);
    logic [31:0] w;
    case (op)
      OP_R:      w = {1'b0, f7b, 5'b0, rs2, rs1, f3, rd, op};
      OP_IMM: begin
        // Shift-immediate forms carry funct7 in the upper immediate bits.
        if (f3 == 3'b001)      w = {7'b0, imm[4:0], rs1, f3, rd, op};
        else if (f3 == 3'b101) w = {1'b0, f7b, 5'b0, imm[4:0], rs1, f3, rd, op};
        else                   w = {imm[11:0], rs1, f3, rd, op};
      end
      OP_LOAD, OP_JALR: w = {imm[11:0], rs1, f3, rd, op};
      OP_STORE:  w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
      OP_BRANCH: w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
      OP_LUI, OP_AUIPC: w = {imm[31:12], rd, op};
      OP_JAL:    w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      default:   w = 32'h0;
    endcase
    return w;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       count_q, count_d;
  logic              err_q, err_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    cnt_q, cnt_d;
  logic [31:0]       mem_q [FIFO_DEPTH];
  logic [31:0]       word_d;

  logic fifo_empty, fifo_full, in_ready, wr_en, accept, legal, push, pop;

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == DEPTH_C);
  assign word_d     = enc_word(bus.opcode, bus.funct3, bus.funct7_5b, bus.rd, bus.rs1,
                               bus.rs2, bus.imm);
`ifdef RISCV_ENC_ILLEGAL_CHK_EN
  assign legal = known_op(bus.opcode) && fields_ok(bus.opcode, bus.funct3, bus.funct7_5b);
`else
  assign legal = known_op(bus.opcode);
`endif
  assign accept = bus.in_valid && in_ready;
  assign push   = accept && legal;
  assign pop    = wr_en && bus.imem_ack;

  // ---- state register ----
  always_ff @(posedge i_clk) begin
    if (!i_rstn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // ---- next-state logic ----
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_start)    state_d = S_RUN;
      S_RUN:   if (i_stop)     state_d = S_DRAIN;
      S_DRAIN: if (fifo_empty) state_d = S_IDLE;
      default:                 state_d = S_IDLE;
    endcase
  end

  // ---- output logic ----
  always_comb begin
    in_ready          = (state_q == S_RUN) && !fifo_full;
    wr_en             = !fifo_empty;
    o_busy            = (state_q != S_IDLE);
    bus.imem_wr_data  = fifo_empty ? 32'h0 : mem_q[rd_ptr_q];
  end

  assign bus.in_ready   = in_ready;
  assign bus.imem_wr_en = wr_en;
  assign bus.imem_addr  = addr_q;
  assign o_err_illegal  = err_q;
  assign o_count        = count_q;

  // ---- address, counters and FIFO pointers ----
  always_comb begin
    addr_d   = addr_q;
    count_d  = count_q;
    err_d    = err_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (state_q == S_IDLE && i_start) begin
      addr_d  = i_base_addr & ~ADDR_W'(3);
      count_d = 16'h0;
      err_d   = 1'b0;
    end
    if (accept && !legal) err_d = 1'b1;
    if (pop) begin
      addr_d   = addr_q + ADDR_W'(4);
      count_d  = sat_inc16(count_q);
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
      2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      addr_q   <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      addr_q   <= addr_d;
      count_q  <= count_d;
      err_q    <= err_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Buffer storage carries data only; validity lives in the pointers and occupancy.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= word_d;
  end
endmodule

// File: tb/tb_riscv_instr_enc.sv
// Self-checking bench for riscv_instr_enc: scoreboard of expected (addr, word) pairs
// popped by a write monitor, plus per-scenario checks of handshake and status outputs.
`timescale 1ns/1ps
module tb_riscv_instr_enc;
  localparam int ADDR_W     = 32;
  localparam int FIFO_DEPTH = 4;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              busy;
  logic              err_illegal;
  logic [15:0]       count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0]       sb_q [$];
  logic [ADDR_W-1:0] exp_addr = '0;
  logic [15:0]       exp_count = '0;

  riscv_instr_enc_if #(.ADDR_W(ADDR_W)) bus ();

  riscv_instr_enc #(.FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W)) dut (
    .i_clk        (clk),
    .i_rstn       (rstn),
    .i_start      (start),
    .i_stop       (stop),
    .i_base_addr  (base_addr),
    .bus          (bus),
    .o_busy       (busy),
    .o_err_illegal(err_illegal),
    .o_count      (count)
  );

  always #5 clk = ~clk;

  task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic f7b,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm, input logic exp_push, input logic [31:0] exp_w);
    int k;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.opcode = op; bus.funct3 = f3; bus.funct7_5b = f7b;
    bus.rd = rd; bus.rs1 = rs1; bus.rs2 = rs2; bus.imm = imm;
    k = 0;
    while (bus.in_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (k >= 50) begin
      n_fail++;
      $display("FAIL send_accept: in_ready=%b after %0d cycles, required 1", bus.in_ready, k);
    end else if (exp_push) begin
      sb_q.push_back({exp_addr, exp_w});
      exp_addr  = exp_addr + 32'd4;
      exp_count = exp_count + 16'd1;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_sb_empty(output bit ok);
    int k;
    k = 0;
    ok = 1'b0;
    while (k < 60) begin
      @(posedge clk); #1;
      if (sb_q.size() == 0 && bus.imem_wr_en === 1'b0) begin
        ok = 1'b1;
        break;
      end
      k++;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; bus.imem_ack = 1'b0; bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.imem_wr_en, busy, err_illegal, bus.in_ready} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: wr_en/busy/err/ready=%b, required 0000",
               {bus.imem_wr_en, busy, err_illegal, bus.in_ready});
    end
    n_checks++;
    if (count !== 16'h0 || bus.imem_addr !== 32'h0 || bus.imem_wr_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_values: count=%h addr=%h data=%h, required 0 0 0",
               count, bus.imem_addr, bus.imem_wr_data);
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_start();
    @(negedge clk);
    base_addr = 32'h0000_0101;
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    exp_addr = 32'h0000_0100; exp_count = 16'h0;
    n_checks++;
    if (busy !== 1'b1 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL start_stop_idle: busy=%b ready=%b, required 1 1", busy, bus.in_ready);
    end
    n_checks++;
    if (bus.imem_addr !== 32'h0000_0100 || count !== 16'h0) begin
      n_fail++;
      $display("FAIL start_addr: addr=%h count=%h, required 00000100 0000", bus.imem_addr, count);
    end
    bus.imem_ack = 1'b1;
  endtask

  task automatic test_r_type();
    bit ok;
    send(7'b0110011, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 32'h0, 1'b1, 32'h003100B3);
    n_checks++;
    if (bus.imem_wr_en !== 1'b1 || bus.imem_wr_data !== 32'h003100B3) begin
      n_fail++;
      $display("FAIL add_latency: wr_en=%b data=%h, required 1 003100b3",
               bus.imem_wr_en, bus.imem_wr_data);
    end
    send(7'b0110011, 3'b000, 1'b1, 5'd1, 5'd2, 5'd3, 32'h0, 1'b1, 32'h403100B3);
    wait_sb_empty(ok);
    n_checks++;
    if (!ok || count !== exp_count) begin
      n_fail++;
      $display("FAIL r_type_count: drained=%b count=%0d, required 1 %0d", ok, count, exp_count);
    end
  endtask

  task automatic test_i_type();
    bit ok;
    send(7'b0010011, 3'b101, 1'b1, 5'd5, 5'd5, 5'd0, 32'd3, 1'b1, 32'h4032D293);
    send(7'b0010011, 3'b001, 1'b1, 5'd1, 5'd1, 5'd0, 32'd2, 1'b1, 32'h00209093);
    send(7'b0010011, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b1, 32'hFFF00093);
    send(7'b0000011, 3'b010, 1'b0, 5'd4, 5'd2, 5'd0, 32'd4, 1'b1, 32'h00412203);
    wait_sb_empty(ok);
    n_checks++;
    if (!ok || count !== exp_count) begin
      n_fail++;
      $display("FAIL i_type_count: drained=%b count=%0d, required 1 %0d", ok, count, exp_count);
    end
  endtask

  task automatic test_b_j_u_s();
    bit ok;
    send(7'b1100011, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFF8, 1'b1, 32'hFE208CE3);
    send(7'b1101111, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'h0000_0800, 1'b1, 32'h001000EF);
    send(7'b0110111, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 1'b1, 32'h123452B7);
    send(7'b0100011, 3'b010, 1'b0, 5'd0, 5'd2, 5'd3, 32'd8, 1'b1, 32'h00312423);
    wait_sb_empty(ok);
    n_checks++;
    if (!ok || count !== exp_count) begin
      n_fail++;
      $display("FAIL bjus_count: drained=%b count=%0d, required 1 %0d", ok, count, exp_count);
    end
  endtask

  task automatic test_fifo_full();
    logic [63:0] head;
    bus.imem_ack = 1'b0;
    send(7'b0010111, 3'b000, 1'b0, 5'd2, 5'd0, 5'd0, 32'hFFFF_F000, 1'b1, 32'hFFFFF117);
    send(7'b1100111, 3'b000, 1'b0, 5'd0, 5'd1, 5'd0, 32'h0, 1'b1, 32'h00008067);
    send(7'b0100011, 3'b010, 1'b0, 5'd0, 5'd2, 5'd3, 32'd8, 1'b1, 32'h00312423);
    send(7'b0010011, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b1, 32'hFFF00093);
    head = sb_q[0];
    n_checks++;
    if (bus.in_ready !== 1'b0 || bus.imem_wr_en !== 1'b1) begin
      n_fail++;
      $display("FAIL full_ready: ready=%b wr_en=%b, required 0 1", bus.in_ready, bus.imem_wr_en);
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.imem_addr, bus.imem_wr_data} !== head || bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_hold: addr=%h data=%h ready=%b, required %h %h 0",
               bus.imem_addr, bus.imem_wr_data, bus.in_ready, head[63:32], head[31:0]);
    end
    bus.imem_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.imem_wr_en !== 1'b1 || sb_q.size() != 1) begin
      n_fail++;
      $display("FAIL burst_mid: wr_en=%b pending=%0d, required 1 1", bus.imem_wr_en, sb_q.size());
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.imem_wr_en !== 1'b0 || sb_q.size() != 0 || count !== exp_count) begin
      n_fail++;
      $display("FAIL burst_end: wr_en=%b pending=%0d count=%0d, required 0 0 %0d",
               bus.imem_wr_en, sb_q.size(), count, exp_count);
    end
  endtask

  task automatic test_illegal();
    bit ok;
    send(7'h7F, 3'b000, 1'b0, 5'd1, 5'd1, 5'd1, 32'h0, 1'b0, 32'h0);
    n_checks++;
    if (err_illegal !== 1'b1 || bus.imem_wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_op: err=%b wr_en=%b, required 1 0", err_illegal, bus.imem_wr_en);
    end
`ifdef RISCV_ENC_ILLEGAL_CHK_EN
    send(7'b1100111, 3'b001, 1'b0, 5'd0, 5'd1, 5'd0, 32'h0, 1'b0, 32'h0);
    send(7'b1100011, 3'b010, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0, 32'h0);
`else
    send(7'b1100111, 3'b001, 1'b0, 5'd0, 5'd1, 5'd0, 32'h0, 1'b1, 32'h00009067);
`endif
    wait_sb_empty(ok);
    n_checks++;
    if (!ok || err_illegal !== 1'b1 || count !== exp_count) begin
      n_fail++;
      $display("FAIL illegal_sticky: drained=%b err=%b count=%0d, required 1 1 %0d",
               ok, err_illegal, count, exp_count);
    end
  endtask

  task automatic test_drain();
    int k;
    @(posedge clk); #1;
    bus.imem_ack = 1'b0;
    send(7'b0110111, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 1'b1, 32'h123452B7);
    send(7'b0110011, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 32'h0, 1'b1, 32'h003100B3);
    start = 1'b1; stop = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b1 || bus.in_ready !== 1'b0 || bus.imem_wr_en !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_hold: busy=%b ready=%b wr_en=%b, required 1 0 1",
               busy, bus.in_ready, bus.imem_wr_en);
    end
    bus.imem_ack = 1'b1;
    k = 0;
    while (busy === 1'b1 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    n_checks++;
    if (busy !== 1'b0 || sb_q.size() != 0 || count !== exp_count) begin
      n_fail++;
      $display("FAIL drain_idle: busy=%b pending=%0d count=%0d, required 0 0 %0d",
               busy, sb_q.size(), count, exp_count);
    end
  endtask

  task automatic test_restart();
    n_checks++;
    if (err_illegal !== 1'b1) begin
      n_fail++;
      $display("FAIL err_idle_sticky: err=%b, required 1", err_illegal);
    end
    @(negedge clk);
    base_addr = 32'h0000_0200; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_addr = 32'h0000_0200; exp_count = 16'h0;
    n_checks++;
    if (err_illegal !== 1'b0 || count !== 16'h0 || bus.imem_addr !== 32'h0000_0200) begin
      n_fail++;
      $display("FAIL restart: err=%b count=%0d addr=%h, required 0 0 00000200",
               err_illegal, count, bus.imem_addr);
    end
  endtask

  task automatic test_reset_mid_write();
    bit ok;
    bus.imem_ack = 1'b0;
    send(7'b0110011, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 32'h0, 1'b1, 32'h003100B3);
    rstn = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (bus.imem_wr_en !== 1'b0 || busy !== 1'b0 || bus.imem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid_write: wr_en=%b busy=%b addr=%h, required 0 0 0",
               bus.imem_wr_en, busy, bus.imem_addr);
    end
    sb_q.delete();
    rstn = 1'b1;
    @(negedge clk);
    base_addr = 32'h0000_0300; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_addr = 32'h0000_0300; exp_count = 16'h0;
    bus.imem_ack = 1'b1;
    send(7'b0110011, 3'b000, 1'b1, 5'd1, 5'd2, 5'd3, 32'h0, 1'b1, 32'h403100B3);
    wait_sb_empty(ok);
    n_checks++;
    if (!ok || count !== 16'd1) begin
      n_fail++;
      $display("FAIL post_reset_write: drained=%b count=%0d, required 1 1", ok, count);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.imem_ack = 1'b0; bus.opcode = '0; bus.funct3 = '0;
    bus.funct7_5b = 1'b0; bus.rd = '0; bus.rs1 = '0; bus.rs2 = '0; bus.imm = '0;
    fork
      forever begin
        @(negedge clk);
        if (rstn && bus.imem_wr_en === 1'b1 && bus.imem_ack === 1'b1) begin
          n_checks++;
          if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL imem_write: unexpected write addr=%h data=%h, required none",
                     bus.imem_addr, bus.imem_wr_data);
          end else begin
            logic [63:0] e;
            e = sb_q.pop_front();
            if ({bus.imem_addr, bus.imem_wr_data} !== e) begin
              n_fail++;
              $display("FAIL imem_write: addr=%h data=%h, required %h %h",
                       bus.imem_addr, bus.imem_wr_data, e[63:32], e[31:0]);
            end
          end
        end
      end
      begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
      end
    join_none
    test_reset();
    test_start();
    test_r_type();
    test_i_type();
    test_b_j_u_s();
    test_fifo_full();
    test_illegal();
    test_drain();
    test_restart();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
